// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate/ALU-op encodings and the control bundle.
package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // 3'b111 is shared: U-type immediate, unsigned loads and unsigned branches.
    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_R     = 3'b110,
        IMM_U     = 3'b111
    } imm_src_e;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RTYPE  = 2'b10,
        ALU_PASS   = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic       reg_wr_en;
        logic       mem_wr_en;
        imm_src_e   imm_src;
        logic       alu_src;
        logic       branch;
        logic       result_src;
        alu_op_e    alu_op;
        logic [3:0] byte_en;
        logic       alu_src_a_sel;
        logic       mul_div;
        logic       illegal;
    } ctrl_bundle_t;

    // An illegal encoding carries no side effects, only the illegal flag.
    function automatic ctrl_bundle_t illegal_bundle();
        ctrl_bundle_t b;
        b         = '0;
        b.illegal = 1'b1;
        return b;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational main decoder: instruction fields to control bundle.
module decode_logic
    import decode_pkg::*;
#(
    parameter int EN_M_EXT = 0
) (
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    output ctrl_bundle_t o_ctrl
);

    ctrl_bundle_t w_ctrl;
    logic         w_bad;

    // Decode the opcode, then collapse any unsupported sub-encoding to the illegal bundle.
    always_comb begin
        w_ctrl = '0;
        w_bad  = 1'b0;
        case (i_opcode)
            OP_LOAD: begin
                w_ctrl.reg_wr_en  = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.result_src = 1'b1;
                case (i_funct3)
                    3'd0: w_ctrl.byte_en = 4'b0001;
                    3'd1: w_ctrl.byte_en = 4'b0011;
                    3'd2: w_ctrl.byte_en = 4'b1111;
                    3'd4: begin
                        w_ctrl.byte_en = 4'b0001;
                        w_ctrl.imm_src = IMM_U;
                    end
                    3'd5: begin
                        w_ctrl.byte_en = 4'b0011;
                        w_ctrl.imm_src = IMM_U;
                    end
                    default: w_bad = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_ctrl.reg_wr_en = 1'b1;
                w_ctrl.alu_src   = 1'b1;
                if (i_funct3 == 3'b001 || i_funct3 == 3'b101)
                    w_ctrl.imm_src = IMM_SHAMT;
            end
            OP_STORE: begin
                w_ctrl.mem_wr_en  = 1'b1;
                w_ctrl.imm_src    = IMM_S;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.alu_op     = ALU_PASS;
                w_ctrl.result_src = 1'b1;
                case (i_funct3)
                    3'd0:    w_ctrl.byte_en = 4'b0001;
                    3'd1:    w_ctrl.byte_en = 4'b0011;
                    3'd2:    w_ctrl.byte_en = 4'b1111;
                    default: w_bad = 1'b1;
                endcase
            end
            OP_R: begin
                w_ctrl.reg_wr_en = 1'b1;
                w_ctrl.alu_op    = ALU_RTYPE;
                w_ctrl.imm_src   = IMM_R;
                if (i_funct7 == 7'b0000001) begin
                    if (EN_M_EXT != 0) w_ctrl.mul_div = 1'b1;
                    else               w_bad = 1'b1;
                end else if (i_funct7 != 7'b0000000 && i_funct7 != 7'b0100000) begin
                    w_bad = 1'b1;
                end
            end
            OP_BRANCH: begin
                w_ctrl.branch  = 1'b1;
                w_ctrl.alu_op  = ALU_BRANCH;
                w_ctrl.imm_src = (i_funct3[2:1] == 2'b11) ? IMM_U : IMM_B;
                if (i_funct3[2:1] == 2'b01) w_bad = 1'b1;
            end
            OP_JAL: begin
                w_ctrl.branch        = 1'b1;
                w_ctrl.imm_src       = IMM_J;
                w_ctrl.alu_src       = 1'b1;
                w_ctrl.reg_wr_en     = 1'b1;
                w_ctrl.result_src    = 1'b1;
                w_ctrl.alu_op        = ALU_PASS;
                w_ctrl.alu_src_a_sel = 1'b1;
            end
            OP_JALR: begin
                w_ctrl.branch     = 1'b1;
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.reg_wr_en  = 1'b1;
                w_ctrl.result_src = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                w_ctrl.alu_src       = 1'b1;
                w_ctrl.reg_wr_en     = 1'b1;
                w_ctrl.imm_src       = IMM_U;
                w_ctrl.alu_op        = ALU_PASS;
                w_ctrl.alu_src_a_sel = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
    end

    assign o_ctrl = w_bad ? illegal_bundle() : w_ctrl;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decoder feeding a small skid FIFO with valid/ready on both sides.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2,
    parameter int EN_M_EXT = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [XLEN-1:0]  instr_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic             flush_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [XLEN-1:0]  instr_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             reg_wr_en_o,
    output logic             mem_wr_en_o,
    output logic [2:0]       imm_src_o,
    output logic             alu_src_o,
    output logic             branch_o,
    output logic             result_src_o,
    output logic [1:0]       alu_op_o,
    output logic [3:0]       byte_en_o,
    output logic             alu_src_a_sel_o,
    output logic             mul_div_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] decoded_cnt_o,
    output logic [CNT_W-1:0] illegal_cnt_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0]       DEPTH_C  = 2'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    ctrl_bundle_t     r_ctrl  [0:DEPTH-1];
    logic [XLEN-1:0]  r_instr [0:DEPTH-1];
    logic [XLEN-1:0]  r_pc    [0:DEPTH-1];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [1:0]       r_count;
    logic [CNT_W-1:0] r_decoded_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    ctrl_bundle_t     w_dec;
    ctrl_bundle_t     w_head;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    decode_logic #(.EN_M_EXT(EN_M_EXT)) u_decode (
        .i_opcode (instr_i[6:0]),
        .i_funct3 (instr_i[14:12]),
        .i_funct7 (instr_i[31:25]),
        .o_ctrl   (w_dec)
    );

    // ready_o looks only at registered occupancy, so a full buffer cannot push-through on a pop.
    assign ready_o = (r_count < DEPTH_C);
    assign valid_o = (r_count != 2'd0);
    assign w_push  = valid_i & ready_o & ~flush_i;
    assign w_pop   = valid_o & ready_i & ~flush_i;

    // Payload storage; stale contents are harmless because the head is zero-gated.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ctrl[r_wr_ptr]  <= w_dec;
            r_instr[r_wr_ptr] <= instr_i;
            r_pc[r_wr_ptr]    <= pc_i;
        end
    end

    // Pointer and occupancy tracking; reset wins over flush.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Saturating statistics; flush leaves them alone, only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_decoded_cnt <= '0;
            r_illegal_cnt <= '0;
        end else if (w_push) begin
            if (r_decoded_cnt != '1) r_decoded_cnt <= r_decoded_cnt + 1'b1;
            if (w_dec.illegal && r_illegal_cnt != '1) r_illegal_cnt <= r_illegal_cnt + 1'b1;
        end
    end

    assign w_head  = valid_o ? r_ctrl[r_rd_ptr]  : '0;
    assign instr_o = valid_o ? r_instr[r_rd_ptr] : '0;
    assign pc_o    = valid_o ? r_pc[r_rd_ptr]    : '0;

    assign reg_wr_en_o     = w_head.reg_wr_en;
    assign mem_wr_en_o     = w_head.mem_wr_en;
    assign imm_src_o       = w_head.imm_src;
    assign alu_src_o       = w_head.alu_src;
    assign branch_o        = w_head.branch;
    assign result_src_o    = w_head.result_src;
    assign alu_op_o        = w_head.alu_op;
    assign byte_en_o       = w_head.byte_en;
    assign alu_src_a_sel_o = w_head.alu_src_a_sel;
    assign mul_div_o       = w_head.mul_div;
    assign illegal_o       = w_head.illegal;
    assign decoded_cnt_o   = r_decoded_cnt;
    assign illegal_cnt_o   = r_illegal_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: instance A uses defaults, instance B is DEPTH=1, EN_M_EXT=1, CNT_W=4.
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, valid_i, flush_i, ready_i;
    logic [31:0] instr_i, pc_i;

    logic        a_ready, a_valid, a_rw, a_mw, a_as, a_br, a_rs, a_asa, a_md, a_il;
    logic [31:0] a_instr, a_pc;
    logic [2:0]  a_imm;
    logic [1:0]  a_op;
    logic [3:0]  a_be;
    logic [15:0] a_dec, a_ilc;

    logic        b_ready, b_valid, b_rw, b_mw, b_as, b_br, b_rs, b_asa, b_md, b_il;
    logic [31:0] b_instr, b_pc;
    logic [2:0]  b_imm;
    logic [1:0]  b_op;
    logic [3:0]  b_be;
    logic [3:0]  b_dec, b_ilc;

    logic [16:0] a_bun, b_bun;
    assign a_bun = {a_rw, a_mw, a_imm, a_as, a_br, a_rs, a_op, a_be, a_asa, a_md, a_il};
    assign b_bun = {b_rw, b_mw, b_imm, b_as, b_br, b_rs, b_op, b_be, b_asa, b_md, b_il};

    always #5 clk = ~clk;

    decode_stage dut_a (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(a_ready), .instr_i(instr_i),
        .pc_i(pc_i), .flush_i(flush_i), .valid_o(a_valid), .ready_i(ready_i),
        .instr_o(a_instr), .pc_o(a_pc), .reg_wr_en_o(a_rw), .mem_wr_en_o(a_mw),
        .imm_src_o(a_imm), .alu_src_o(a_as), .branch_o(a_br), .result_src_o(a_rs),
        .alu_op_o(a_op), .byte_en_o(a_be), .alu_src_a_sel_o(a_asa), .mul_div_o(a_md),
        .illegal_o(a_il), .decoded_cnt_o(a_dec), .illegal_cnt_o(a_ilc)
    );

    decode_stage #(.DEPTH(1), .EN_M_EXT(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(b_ready), .instr_i(instr_i),
        .pc_i(pc_i), .flush_i(flush_i), .valid_o(b_valid), .ready_i(ready_i),
        .instr_o(b_instr), .pc_o(b_pc), .reg_wr_en_o(b_rw), .mem_wr_en_o(b_mw),
        .imm_src_o(b_imm), .alu_src_o(b_as), .branch_o(b_br), .result_src_o(b_rs),
        .alu_op_o(b_op), .byte_en_o(b_be), .alu_src_a_sel_o(b_asa), .mul_div_o(b_md),
        .illegal_o(b_il), .decoded_cnt_o(b_dec), .illegal_cnt_o(b_ilc)
    );

    typedef struct {
        logic [31:0]  instr;
        ctrl_bundle_t ea;
        ctrl_bundle_t eb;
    } vec_t;

    vec_t vt[25];
    int   nv = 0;
    int   total = 0;
    int   bad = 0;
    int   mad = 0, mai = 0, mbd = 0, mbi = 0;

    // Bundle builder: rw, mw, imm, alu_src, branch, result_src, alu_op, be, a_sel, mul_div, illegal
    function automatic ctrl_bundle_t mk(input logic rw, input logic mw, input logic [2:0] imm,
                                        input logic asrc, input logic br, input logic rs,
                                        input logic [1:0] op, input logic [3:0] be,
                                        input logic asa, input logic md, input logic il);
        return ctrl_bundle_t'({rw, mw, imm, asrc, br, rs, op, be, asa, md, il});
    endfunction

    function automatic void add(input logic [31:0] ins, input ctrl_bundle_t e);
        vt[nv] = '{ins, e, e};
        nv++;
    endfunction

    function automatic logic [31:0] addi_k(input int k);
        return {12'(k), 5'd1, 3'b000, 5'd2, 7'b0010011};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    initial begin
        ctrl_bundle_t ILL;
        ILL = mk(0, 0, 3'b000, 0, 0, 0, 2'b00, 4'b0000, 0, 0, 1);
        add(32'h0000A283, mk(1, 0, 3'b000, 1, 0, 1, 2'b00, 4'b1111, 0, 0, 0)); // lw
        add(32'h00008283, mk(1, 0, 3'b000, 1, 0, 1, 2'b00, 4'b0001, 0, 0, 0)); // lb
        add(32'h00009283, mk(1, 0, 3'b000, 1, 0, 1, 2'b00, 4'b0011, 0, 0, 0)); // lh
        add(32'h0000C283, mk(1, 0, 3'b111, 1, 0, 1, 2'b00, 4'b0001, 0, 0, 0)); // lbu
        add(32'h0000D283, mk(1, 0, 3'b111, 1, 0, 1, 2'b00, 4'b0011, 0, 0, 0)); // lhu
        add(32'h0000B283, ILL);                                                   // load f3=3
        add(32'h00108093, mk(1, 0, 3'b000, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 0)); // addi
        add(32'h00109093, mk(1, 0, 3'b101, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 0)); // slli
        add(32'h4010D093, mk(1, 0, 3'b101, 1, 0, 0, 2'b00, 4'b0000, 0, 0, 0)); // srai
        add(32'h00208023, mk(0, 1, 3'b001, 1, 0, 1, 2'b11, 4'b0001, 0, 0, 0)); // sb
        add(32'h0020A023, mk(0, 1, 3'b001, 1, 0, 1, 2'b11, 4'b1111, 0, 0, 0)); // sw
        add(32'h0020B023, ILL);                                                   // store f3=3
        add(32'h002081B3, mk(1, 0, 3'b110, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 0)); // add
        add(32'h402081B3, mk(1, 0, 3'b110, 0, 0, 0, 2'b10, 4'b0000, 0, 0, 0)); // sub
        add(32'h02B50533, ILL);                                                   // mul
        add(32'h04B50533, ILL);                                                   // op f7=2
        add(32'h00208463, mk(0, 0, 3'b010, 0, 1, 0, 2'b01, 4'b0000, 0, 0, 0)); // beq
        add(32'h0020E463, mk(0, 0, 3'b111, 0, 1, 0, 2'b01, 4'b0000, 0, 0, 0)); // bltu
        add(32'h0020A463, ILL);                                                   // branch f3=2
        add(32'h008000EF, mk(1, 0, 3'b100, 1, 1, 1, 2'b11, 4'b0000, 1, 0, 0)); // jal
        add(32'h000080E7, mk(1, 0, 3'b000, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0)); // jalr
        add(32'h123452B7, mk(1, 0, 3'b111, 1, 0, 0, 2'b11, 4'b0000, 1, 0, 0)); // lui
        add(32'h00001297, mk(1, 0, 3'b111, 1, 0, 0, 2'b11, 4'b0000, 1, 0, 0)); // auipc
        add(32'h0000000F, ILL);                                                   // fence
        add(32'h00000000, ILL);                                                   // zero word
        vt[14].eb = mk(1, 0, 3'b110, 0, 0, 0, 2'b10, 4'b0000, 0, 1, 0);          // mul with M

        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        instr_i = '0; pc_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", a_valid, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_bundle", a_bun, 0);
        chk("rst_dec_cnt", a_dec, 0);
        chk("rst_b_ready", b_ready, 1);

        // Decode table: one instruction at a time through an empty buffer.
        for (int i = 0; i < nv; i++) begin
            valid_i = 1'b1; instr_i = vt[i].instr; pc_i = 32'h1000 + 32'(4 * i); ready_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            valid_i = 1'b0;
            chk($sformatf("vec%0d_valid", i), a_valid, 1);
            chk($sformatf("vec%0d_a_bundle", i), a_bun, vt[i].ea);
            chk($sformatf("vec%0d_instr", i), a_instr, vt[i].instr);
            chk($sformatf("vec%0d_pc", i), a_pc, 32'h1000 + 32'(4 * i));
            chk($sformatf("vec%0d_b_bundle", i), b_bun, vt[i].eb);
            mad++; mai += int'(vt[i].ea.illegal);
            if (mbd < 15) mbd++;
            if (vt[i].eb.illegal && mbi < 15) mbi++;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_drain", i), {a_valid, a_bun}, 0);
        end
        chk("a_dec_cnt", a_dec, 64'(mad));
        chk("a_ill_cnt", a_ilc, 64'(mai));
        chk("b_dec_sat", b_dec, 64'(mbd));
        chk("b_ill_cnt", b_ilc, 64'(mbi));

        // Backpressure on A: ADD, SB fill it, BEQ is held upstream until space opens.
        ready_i = 1'b0; valid_i = 1'b1; instr_i = 32'h002081B3;
        @(posedge clk); @(negedge clk);
        instr_i = 32'h00208023;
        @(posedge clk); @(negedge clk);
        chk("bp_full_ready", a_ready, 0);
        instr_i = 32'h00208463;
        @(posedge clk); @(negedge clk);
        chk("bp_head_add", a_instr, 32'h002081B3);
        chk("bp_still_full", a_ready, 0);
        ready_i = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("bp_head_sb", a_instr, 32'h00208023);
        chk("bp_sb_be", a_be, 4'b0001);
        chk("bp_ready_back", a_ready, 1);
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        chk("bp_head_beq", a_instr, 32'h00208463);
        chk("bp_beq_branch", a_br, 1);
        @(posedge clk); @(negedge clk);
        chk("bp_empty", a_valid, 0);
        chk("bp_dec_cnt", a_dec, 64'(mad + 3));

        // Flush: full buffer with a coincident input, then an empty buffer with one.
        ready_i = 1'b0; valid_i = 1'b1; instr_i = addi_k(7);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("fl_full", a_ready, 0);
        flush_i = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("fl_valid", a_valid, 0);
        chk("fl_ready", a_ready, 1);
        chk("fl_dec_cnt", a_dec, 64'(mad + 5));
        @(posedge clk); @(negedge clk);
        chk("fl_empty_valid", a_valid, 0);
        chk("fl_empty_dec_cnt", a_dec, 64'(mad + 5));
        flush_i = 1'b0; valid_i = 1'b0;

        // Streaming: A sustains one per cycle, B alternates ready.
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("st_b_cnt_clear", {b_dec, b_ilc}, 0);
        ready_i = 1'b1;
        for (int k = 0; k < 100; k++) begin
            valid_i = 1'b1; instr_i = addi_k(k); pc_i = 32'h2000 + 32'(4 * k);
            @(posedge clk); @(negedge clk);
            chk($sformatf("st%0d_a_instr", k), a_instr, addi_k(k));
            chk($sformatf("st%0d_a_pc", k), a_pc, 32'h2000 + 32'(4 * k));
            chk($sformatf("st%0d_b_ready", k), b_ready, 64'(k % 2));
        end
        valid_i = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("st_a_dec_cnt", a_dec, 100);
        chk("st_b_dec_sat", b_dec, 15);
        chk("st_b_ill_cnt", b_ilc, 0);

        // Reset in the middle of a backed-up stream.
        ready_i = 1'b0; valid_i = 1'b1; instr_i = addi_k(3); pc_i = 32'h0000_0BAD;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; valid_i = 1'b0;
        chk("mr_a_valid", a_valid, 0);
        chk("mr_a_ready", a_ready, 1);
        chk("mr_a_cnts", {a_dec, a_ilc}, 0);
        chk("mr_b_valid", b_valid, 0);
        chk("mr_b_cnts", {b_dec, b_ilc}, 0);
        valid_i = 1'b1; instr_i = 32'h123452B7; pc_i = 32'h3000;
        @(posedge clk); @(negedge clk);
        valid_i = 1'b0;
        chk("mr_head_instr", a_instr, 32'h123452B7);
        chk("mr_head_pc", a_pc, 32'h3000);
        chk("mr_dec_cnt", a_dec, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, handshaked instruction-decode stage. It is the pipelined successor of the combinational main decoder.
- It accepts a fetched instruction plus its PC and decodes the control bundle. Results are buffered in a DEPTH-entry skid FIFO and presented to the execute stage under valid/ready.
- It adds illegal-instruction detection, optional M-extension decode, flush, and saturating statistics counters.

Parameters:
- XLEN, 32, width of instr_i, pc_i, instr_o and pc_o.
- DEPTH, 2, output buffer entries. Legal values are 1 and 2. With 2, throughput is 1 instruction per cycle; with 1, throughput is 1 instruction per 2 cycles.
- EN_M_EXT, 0, when 1, OP with funct7=0000001 decodes as mul/div; when 0, it is illegal.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  stage can accept; equals (count < DEPTH), registered state only.
- instr_i  in  XLEN  instruction word.
- pc_i  in  XLEN  instruction PC.
- flush_i  in  1  discard all buffered entries and the current input.
- valid_o  out  1  head entry valid.
- ready_i  in  1  downstream accepts head.
- instr_o  out  XLEN  head instruction.
- pc_o  out  XLEN  head PC.
- reg_wr_en_o  out  1  register write enable.
- mem_wr_en_o  out  1  memory write enable.
- imm_src_o  out  3  immediate format select.
- alu_src_o  out  1  ALU operand B: 0 = register, 1 = immediate.
- branch_o  out  1  branch or jump.
- result_src_o  out  1  result select.
- alu_op_o  out  2  ALU operation class.
- byte_en_o  out  4  byte enable.
- alu_src_a_sel_o  out  1  ALU operand A = PC.
- mul_div_o  out  1  M-extension operation.
- illegal_o  out  1  unsupported encoding.
- decoded_cnt_o  out  CNT_W  number of accepted instructions, saturating.
- illegal_cnt_o  out  CNT_W  number of accepted illegal instructions, saturating.

Behaviour:
- Reset (rst=1 at a rising edge):
  - count=0; FIFO pointers=0; both counters=0.
  - valid_o=0 and ready_o=1 in the following cycle.
  - Bundle outputs read as 0 whenever valid_o=0; the muxed head is zero-gated.
  - Reset mid-stream drops every entry, with no partial state retained.
- Push occurs when valid_i & ready_o & !flush_i. The decode is computed combinationally from instr_i and written into the tail entry together with pc_i and instr_i.
- Pop occurs when valid_o & ready_i & !flush_i. The head advances.
- Push and pop in the same cycle leave count unchanged; FIFO order is preserved.
- Latency: an instruction pushed at edge N is visible on valid_o after edge N, provided the FIFO was empty.
- Flush: at the edge, count=0 and pointers=0; the coincident input is dropped and not counted. Counters are not cleared. Reset has priority over flush.
- Pointers wrap modulo DEPTH. Pushing when count=DEPTH is impossible because ready_o=0.
- Counters: decoded_cnt increments on every push; illegal_cnt increments on every push whose illegal=1. Both saturate at all-ones.
- Decode table (opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]). Any field not listed below is 0.
  - LOAD 0000011: reg_wr=1, alu_src=1, result_src=1.
    - f3=0: be=0001, imm=000.
    - f3=1: be=0011, imm=000.
    - f3=2: be=1111, imm=000.
    - f3=4: be=0001, imm=111.
    - f3=5: be=0011, imm=111.
    - Other f3: illegal.
  - OP-IMM 0010011: reg_wr=1, alu_src=1. imm=101 when f3 is 001 or 101, else imm=000.
  - STORE 0100011: mem_wr=1, imm=001, alu_src=1, alu_op=11, result_src=1.
    - f3 0/1/2 give be 0001/0011/1111.
    - Other f3: illegal.
  - OP 0110011: reg_wr=1, alu_op=10, imm=110.
    - f7=0000001: mul_div=1 if EN_M_EXT, else illegal.
    - f7 not 0000000, 0100000 or 0000001: illegal.
  - BRANCH 1100011: branch=1, alu_op=01. imm=111 for f3 110/111, else imm=010. f3 010/011: illegal.
  - JAL 1101111: branch=1, imm=100, alu_src=1, reg_wr=1, result_src=1, alu_op=11, alu_src_a_sel=1.
  - JALR 1100111: branch=1, imm=000, alu_src=1, reg_wr=1, result_src=1.
  - LUI 0110111 and AUIPC 0010111: alu_src=1, reg_wr=1, imm=111, alu_op=11, alu_src_a_sel=1.
  - Any other opcode, or an illegal case above: every field is forced to 0 except illegal=1. The entry still propagates down the pipeline.

Decomposition:
- decode_pkg holds:
  - the opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_R, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - the imm_src and alu_op enums;
  - ctrl_bundle_t, a packed struct of all control outputs.
- One combinational sub-module, decode_logic, maps instr to ctrl_bundle_t and takes EN_M_EXT as a parameter.
- decode_stage owns the FIFO, the handshake and the counters.

Test Plan:
- Reset, then push LW 0x0000A283 with ready_i=1. Next cycle: valid_o=1, reg_wr=1, result_src=1, be=1111, imm=000, decoded_cnt=1.
- DEPTH=2, ready_i=0, push ADD, SB, BEQ back-to-back. The third push is blocked because ready_o=0 after two pushes. Raise ready_i: entries emerge in order ADD, SB, BEQ, with SB be=0001.
- EN_M_EXT=0, push MUL 0x02B50533 → illegal_o=1, all other fields 0, illegal_cnt=1. With EN_M_EXT=1 the same word gives mul_div_o=1, alu_op=10, illegal=0.
- Fill the FIFO, then assert flush_i together with valid_i. Next cycle: valid_o=0, ready_o=1, and decoded_cnt is unchanged by the flushed input.
- Streaming at DEPTH=2 with ready_i=1: 100 instructions in 100 cycles. At DEPTH=1: 1 instruction per 2 cycles.
- CNT_W=4: push 20 instructions → decoded_cnt_o saturates at 15. Asserting rst mid-stream clears the counters, valid_o and count.
